// File: rtl/clk_ratio_meter.sv
`default_nettype none
// ============================================================================
//  Module   : clk_ratio_meter
//  Purpose  : Measures period and high time of a divided clock (sig_in) in
//             clkin cycles, reports lock once the ratio is stable, and flags
//             dead or stuck inputs with a sticky timeout.
//  Revision : 1.0  initial release
// ============================================================================
module clk_ratio_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int                c_MC_W     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  c_MAX      = '1;
    localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);
    localparam logic [c_MC_W-1:0] c_LOCK     = c_MC_W'(LOCK_N);
    localparam logic [c_MC_W-1:0] c_MC_ONE   = c_MC_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;   // waiting for a reference edge
    localparam logic [1:0] ARMED = 2'd1;   // one edge seen, next edge measures
    localparam logic [1:0] TRACK = 2'd2;   // measuring and comparing

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt_p;
    logic [CNT_W-1:0]  r_cnt_h;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_high;
    logic              r_meas_valid;
    logic              r_locked;
    logic              r_timeout;
    logic [c_MC_W-1:0] r_match_cnt;

    logic              w_rise;
    logic              w_timeout_hit;
    logic              w_match;
    logic [c_MC_W-1:0] w_mc_next;

    // Rising edge of the synchronised input; a rise at cnt_p==MAX is a
    // legitimate period-MAX measurement, so it suppresses the timeout.
    assign w_rise        = r_s2 & ~r_s3;
    assign w_timeout_hit = (r_cnt_p == c_MAX) && !w_rise;
    // Compare the counts that are about to be loaded against the last result.
    assign w_match       = (r_cnt_p == r_period) && (r_cnt_h == r_high);
    assign w_mc_next     = !w_match ? '0 :
                           (r_match_cnt >= c_LOCK) ? c_LOCK : r_match_cnt + c_MC_ONE;

    // Three-flop synchronizer; reset preloads sig_in so no edge appears on exit.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_s1 <= sig_in;
            r_s2 <= sig_in;
            r_s3 <= sig_in;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Saturating period and high-time counters, restarted on every rise.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_cnt_p <= '0;
            r_cnt_h <= '0;
        end else if (w_rise) begin
            r_cnt_p <= c_ONE;
            r_cnt_h <= c_ONE;
        end else begin
            if (r_cnt_p != c_MAX) begin
                r_cnt_p <= r_cnt_p + c_ONE;
            end
            if (r_cnt_h != c_MAX) begin
                r_cnt_h <= r_cnt_h + {{(CNT_W-1){1'b0}}, r_s2};
            end
        end
    end

    // Measurement FSM: capture results on rise, track lock, handle timeout.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state      <= IDLE;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
            r_match_cnt  <= '0;
        end else begin
            r_meas_valid <= 1'b0;
            if (w_timeout_hit) begin
                r_timeout   <= 1'b1;
                r_state     <= IDLE;
                r_locked    <= 1'b0;
                r_match_cnt <= '0;
                r_period    <= '0;
                r_high      <= '0;
            end else if (w_rise) begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        r_period     <= r_cnt_p;
                        r_high       <= r_cnt_h;
                        r_meas_valid <= 1'b1;
                        r_timeout    <= 1'b0;
                        r_match_cnt  <= '0;
                        r_locked     <= 1'b0;
                        r_state      <= TRACK;
                    end
                    TRACK: begin
                        r_period     <= r_cnt_p;
                        r_high       <= r_cnt_h;
                        r_meas_valid <= 1'b1;
                        r_timeout    <= 1'b0;
                        r_match_cnt  <= w_mc_next;
                        r_locked     <= (w_mc_next >= c_LOCK);
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clk_ratio_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_ratio_meter
//  Purpose  : Directed self-checking bench for clk_ratio_meter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_ratio_meter;

    localparam int CNT_W  = 8;
    localparam int LOCK_N = 3;

    logic             clkin;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    bit to_seen  = 0;

    int mv_per[$];
    int mv_high[$];
    int mv_lock[$];
    int mv_to[$];
    int mv_cyc[$];

    clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // One clock edge, then sample 1 ns later and log any measurement.
    task automatic tick;
        @(posedge clkin);
        #1;
        cyc_n++;
        if (timeout) to_seen = 1'b1;
        if (meas_valid) begin
            mv_per.push_back(int'(period));
            mv_high.push_back(int'(high_time));
            mv_lock.push_back(int'(locked));
            mv_to.push_back(int'(timeout));
            mv_cyc.push_back(cyc_n);
        end
    endtask

    task automatic clear_log;
        mv_per.delete();
        mv_high.delete();
        mv_lock.delete();
        mv_to.delete();
        mv_cyc.delete();
        to_seen = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    // n periods of length p with the first h cycles high.
    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                sig_in = (i < h);
                tick();
            end
        end
    endtask

    task automatic test_reset;
        sig_in = 1'b0;
        do_reset();
        n_checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== '0)
            $display("FAIL reset_outputs: got p=%0d h=%0d mv=%0b lk=%0b to=%0b want all 0",
                     period, high_time, meas_valid, locked, timeout);
        else n_pass++;
    endtask

    task automatic test_div2;
        bit ok_vals = 1'b1;
        bit ok_gap  = 1'b1;
        sig_in = 1'b0;
        do_reset();
        wave(2, 1, 20);
        n_checks++;
        if (mv_per.size() < 18) $display("FAIL div2_count: got %0d want >=18", mv_per.size());
        else n_pass++;
        for (int i = 0; i < mv_per.size(); i++) begin
            if (mv_per[i] != 2 || mv_high[i] != 1) ok_vals = 1'b0;
            if (i > 0 && mv_cyc[i] - mv_cyc[i-1] != 2) ok_gap = 1'b0;
        end
        n_checks++;
        if (!ok_vals) $display("FAIL div2_values: got p=%0d h=%0d want p=2 h=1", mv_per[0], mv_high[0]);
        else n_pass++;
        n_checks++;
        if (!ok_gap) $display("FAIL div2_spacing: meas_valid gap not 2 cycles, got first gap %0d want 2",
                              mv_cyc[1] - mv_cyc[0]);
        else n_pass++;
        n_checks++;
        if (mv_lock[2] != 0 || mv_lock[3] != 1)
            $display("FAIL div2_lock: got lock3=%0d lock4=%0d want 0 1", mv_lock[2], mv_lock[3]);
        else n_pass++;
        n_checks++;
        if (to_seen) $display("FAIL div2_timeout: got 1 want 0");
        else n_pass++;
    endtask

    task automatic test_div5;
        sig_in = 1'b0;
        do_reset();
        wave(5, 2, 5);
        n_checks++;
        if (mv_per.size() != 4 || mv_per[3] != 5 || mv_high[3] != 2)
            $display("FAIL div5_meas: got n=%0d p=%0d h=%0d want n=4 p=5 h=2",
                     mv_per.size(), period, high_time);
        else n_pass++;
        n_checks++;
        if (mv_lock[2] != 0 || mv_lock[3] != 1)
            $display("FAIL div5_lock: got lock3=%0d lock4=%0d want 0 1", mv_lock[2], mv_lock[3]);
        else n_pass++;
        clear_log();
        wave(6, 2, 1);
        wave(5, 2, 5);
        // Measurements: 5 (still locked), 6, 5, 5, 5, 5 (relocks on last).
        n_checks++;
        if (mv_per.size() != 6 || mv_per[1] != 6 || mv_lock[0] != 1 || mv_lock[1] != 0)
            $display("FAIL div5_glitch: got n=%0d p1=%0d lock0=%0d lock1=%0d want n=6 p1=6 lock0=1 lock1=0",
                     mv_per.size(), mv_per[1], mv_lock[0], mv_lock[1]);
        else n_pass++;
        n_checks++;
        if (mv_lock[4] != 0 || mv_lock[5] != 1 || mv_per[5] != 5)
            $display("FAIL div5_relock: got lock4=%0d lock5=%0d p5=%0d want 0 1 5",
                     mv_lock[4], mv_lock[5], mv_per[5]);
        else n_pass++;
    endtask

    task automatic test_stuck_low;
        sig_in = 1'b0;
        do_reset();
        // cnt_p reaches MAX on the 255th edge; timeout registers on the 256th.
        for (int i = 0; i < 255; i++) tick();
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL low_timeout_early: got %0b want 0 at edge 255", timeout);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout !== 1'b1) $display("FAIL low_timeout: got %0b want 1 at edge 256", timeout);
        else n_pass++;
        n_checks++;
        if (mv_per.size() != 0 || locked !== 1'b0)
            $display("FAIL low_no_meas: got n=%0d lk=%0b want n=0 lk=0", mv_per.size(), locked);
        else n_pass++;
        wave(4, 2, 1);
        n_checks++;
        if (timeout !== 1'b1 || mv_per.size() != 0)
            $display("FAIL low_arm_only: got to=%0b n=%0d want to=1 n=0", timeout, mv_per.size());
        else n_pass++;
        wave(4, 2, 2);
        n_checks++;
        if (mv_per.size() != 2 || mv_per[0] != 4 || mv_high[0] != 2 || mv_to[0] != 0)
            $display("FAIL low_recover: got n=%0d p=%0d h=%0d to=%0d want n=2 p=4 h=2 to=0",
                     mv_per.size(), mv_per[0], mv_high[0], mv_to[0]);
        else n_pass++;
    endtask

    task automatic test_stuck_high;
        sig_in = 1'b1;
        do_reset();
        for (int i = 0; i < 255; i++) tick();
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL high_timeout_early: got %0b want 0", timeout);
        else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (timeout !== 1'b1 || mv_per.size() != 0)
            $display("FAIL high_stuck: got to=%0b n=%0d want to=1 n=0", timeout, mv_per.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        sig_in = 1'b0;
        do_reset();
        wave(5, 2, 6);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL mid_prelock: got %0b want 1", locked);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== '0)
            $display("FAIL mid_reset_outputs: got p=%0d h=%0d mv=%0b lk=%0b to=%0b want all 0",
                     period, high_time, meas_valid, locked, timeout);
        else n_pass++;
        rst = 1'b0;
        clear_log();
        wave(5, 2, 3);
        n_checks++;
        if (mv_per.size() != 2 || mv_per[0] != 5 || mv_lock[1] != 0)
            $display("FAIL mid_rearm: got n=%0d p=%0d lk=%0d want n=2 p=5 lk=0",
                     mv_per.size(), mv_per[0], mv_lock[1]);
        else n_pass++;
    endtask

    task automatic test_max_period;
        sig_in = 1'b0;
        do_reset();
        wave(255, 100, 3);
        n_checks++;
        if (mv_per.size() != 2 || mv_per[0] != 255 || mv_high[0] != 100)
            $display("FAIL max_meas: got n=%0d p=%0d h=%0d want n=2 p=255 h=100",
                     mv_per.size(), mv_per[0], mv_high[0]);
        else n_pass++;
        n_checks++;
        if (to_seen) $display("FAIL max_timeout: got 1 want 0");
        else n_pass++;
    endtask

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        test_reset();
        test_div2();
        test_div5();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid();
        test_max_period();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
